// File: rtl/window_buffer_ctrl.sv
// Circular 16-entry window buffer feeding a 16:1 byte-select mux.
// Fills the window, scans it oldest-first, then slides it by a latched stride.
module window_buffer_ctrl #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [3:0]        stride,
  input  logic              stop,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic [DATA_W-1:0] window [0:DEPTH-1],
  output logic [3:0]        sel,
  output logic              sel_valid,
  input  logic              sel_ready,
  output logic              last,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_SCAN = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [3:0]        r_head;
  logic [3:0]        r_wp;
  logic [3:0]        r_idx;
  logic [4:0]        r_count;
  logic [4:0]        r_stride;
  logic              r_done;
  logic [DATA_W-1:0] r_mem [0:DEPTH-1];

  logic              w_full;
  logic              w_in_acc;
  logic              w_sel_acc;
  logic              w_end_scan;
  logic [4:0]        w_stride_in;

  assign w_full      = (r_count == 5'd16);
  assign in_ready    = (r_state == S_FILL) && !w_full;
  assign w_in_acc    = in_valid && in_ready;
  assign sel_valid   = (r_state == S_SCAN);
  assign w_sel_acc   = sel_valid && sel_ready;
  assign last        = sel_valid && (r_idx == 4'd15);
  assign w_end_scan  = w_sel_acc && (r_idx == 4'd15);
  assign sel         = r_head + r_idx;
  assign busy        = (r_state != S_IDLE);
  assign done        = r_done;
  // A stride of 0 encodes a full 16-entry reload.
  assign w_stride_in = (stride == 4'd0) ? 5'd16 : {1'b0, stride};

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      window[i] = r_mem[i];
    end
  end

  // Next-state logic for the fill/scan sequencer.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = w_full ? S_SCAN : S_FILL;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_FILL: begin
        if (w_in_acc && (r_count == 5'd15)) begin
          w_state_nxt = S_SCAN;
        end else begin
          w_state_nxt = S_FILL;
        end
      end
      S_SCAN: begin
        if (w_end_scan) begin
          w_state_nxt = stop ? S_IDLE : S_FILL;
        end else begin
          w_state_nxt = S_SCAN;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State, pointers, counters and window storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_head   <= 4'd0;
      r_wp     <= 4'd0;
      r_idx    <= 4'd0;
      r_count  <= 5'd0;
      r_stride <= 5'd16;
      r_done   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= {DATA_W{1'b0}};
      end
    end else begin
      r_state <= w_state_nxt;
      r_done  <= 1'b0;
      if ((r_state == S_IDLE) && start) begin
        r_stride <= w_stride_in;
      end
      if (w_in_acc) begin
        r_mem[r_wp] <= in_data;
        r_wp        <= r_wp + 4'd1;
        r_count     <= r_count + 5'd1;
      end
      if (w_sel_acc) begin
        if (r_idx == 4'd15) begin
          r_idx <= 4'd0;
          // Stopping re-bases the window on the write pointer so the next frame starts empty.
          if (stop) begin
            r_count <= 5'd0;
            r_head  <= r_wp;
            r_done  <= 1'b1;
          end else begin
            r_head  <= r_head + r_stride[3:0];
            r_count <= 5'd16 - r_stride;
          end
        end else begin
          r_idx <= r_idx + 4'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_window_buffer_ctrl.sv
// Directed, table-driven bench for window_buffer_ctrl: fill, scan, slide, stop and reset.
module tb_window_buffer_ctrl;
  logic       clk = 1'b0;
  logic       rst_n, start, stop, in_valid, sel_ready;
  logic [3:0] stride;
  logic [7:0] in_data;
  logic       in_ready, sel_valid, last, busy, done;
  logic [3:0] sel;
  logic [7:0] window [0:15];

  int n_pass = 0;
  int n_tot  = 0;

  typedef struct {
    logic       rdy;
    logic       stp;
    logic [3:0] e_sel;
    logic [7:0] e_dat;
    logic       e_last;
  } vec_t;
  vec_t tbl[$];

  always #5 clk = ~clk;

  window_buffer_ctrl #(.DATA_W(8), .DEPTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stride(stride), .stop(stop),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready), .window(window),
    .sel(sel), .sel_valid(sel_valid), .sel_ready(sel_ready), .last(last),
    .busy(busy), .done(done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    int nz;
    nz = 0;
    for (int i = 0; i < 16; i++) if (window[i] !== 8'h00) nz++;
    chk({tag, "_window_zero"}, nz, 0);
    chk({tag, "_in_ready"}, in_ready, 1'b0);
    chk({tag, "_sel"}, sel, 4'd0);
    chk({tag, "_sel_valid"}, sel_valid, 1'b0);
    chk({tag, "_last"}, last, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
  endtask

  // Drive bytes base, base+1, ... until limit_wr accepted writes or the cycle budget expires.
  task automatic feed(input logic [7:0] base, input bit toggle, input int limit_wr,
                      output int nwr, output int nready, output int nsv);
    nwr = 0; nready = 0; nsv = 0;
    for (int cyc = 0; cyc < 200 && nwr < limit_wr; cyc++) begin
      in_valid = toggle ? (cyc % 2 == 1) : 1'b1;
      in_data  = base + nwr[7:0];
      if (in_ready) nready++;
      if (sel_valid) nsv++;
      if (in_valid && in_ready) nwr++;
      tick();
    end
    in_valid = 1'b0;
    in_data  = 8'h00;
  endtask

  // Logical entry k holds lo+k for k<split, else hi+(k-split); optional ready stall at hold_at.
  task automatic add_scan(input logic [3:0] head, input logic [7:0] lo, input int split,
                          input logic [7:0] hi, input int hold_at, input int hold_n,
                          input logic stop_last);
    vec_t v;
    for (int k = 0; k < 16; k++) begin
      v.e_sel  = head + 4'(k);
      v.e_dat  = (k < split) ? lo + 8'(k) : hi + 8'(k - split);
      v.e_last = (k == 15);
      if (k == hold_at) begin
        for (int h = 0; h < hold_n; h++) begin
          v.rdy = 1'b0; v.stp = 1'b1;
          tbl.push_back(v);
        end
      end
      v.rdy = 1'b1;
      v.stp = (k == 15) ? stop_last : (k == 3);
      tbl.push_back(v);
    end
  endtask

  // Apply the scan table; start/in_valid noise must be ignored while scanning.
  task automatic run_tbl(input int id, output int nacc);
    nacc = 0;
    foreach (tbl[i]) begin
      in_valid  = 1'b1;
      in_data   = 8'hEE;
      start     = 1'b1;
      stride    = 4'd9;
      sel_ready = tbl[i].rdy;
      stop      = tbl[i].stp;
      chk($sformatf("scan%0d_sel_%0d", id, i), sel, tbl[i].e_sel);
      chk($sformatf("scan%0d_valid_%0d", id, i), sel_valid, 1'b1);
      chk($sformatf("scan%0d_data_%0d", id, i), window[tbl[i].e_sel], tbl[i].e_dat);
      chk($sformatf("scan%0d_last_%0d", id, i), last, tbl[i].e_last);
      if (sel_valid && sel_ready) nacc++;
      tick();
    end
    in_valid = 1'b0; start = 1'b0; sel_ready = 1'b0; stop = 1'b0; in_data = 8'h00;
    tbl.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nwr, nready, nsv, nacc;
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; in_valid = 1'b0; sel_ready = 1'b0;
    stride = 4'd0; in_data = 8'h00;
    #12;
    chk_idle_outputs("reset");
    rst_n = 1'b1;
    tick();

    // Test 1: stride 4, toggling in_valid
    start = 1'b1; stride = 4'd4;
    tick();
    start = 1'b0;
    chk("t1_busy", busy, 1'b1);
    chk("t1_in_ready", in_ready, 1'b1);
    feed(8'h10, 1'b1, 16, nwr, nready, nsv);
    chk("t1_writes", nwr, 16);
    chk("t1_no_early_sel_valid", nsv, 0);
    chk("t1_sel_valid_latency", sel_valid, 1'b1);
    chk("t1_in_ready_full", in_ready, 1'b0);
    add_scan(4'd0, 8'h10, 16, 8'h00, -1, 0, 1'b0);
    run_tbl(1, nacc);
    chk("t1_accepted", nacc, 16);
    chk("t1_fill_after_slide", in_ready, 1'b1);
    chk("t1_no_done", done, 1'b0);

    // Test 2/3/5: refill 4, stall at idx 7, stop on the last beat
    feed(8'h20, 1'b0, 16, nwr, nready, nsv);
    chk("t2_writes", nwr, 4);
    chk("t2_in_ready_beats", nready, 4);
    chk("t2_in_ready_after", in_ready, 1'b0);
    add_scan(4'd4, 8'h14, 12, 8'h20, 7, 3, 1'b1);
    run_tbl(2, nacc);
    chk("t3_accepted", nacc, 16);
    chk("t5_busy", busy, 1'b0);
    chk("t5_done", done, 1'b1);
    chk("t5_sel_valid", sel_valid, 1'b0);
    tick();
    chk("t5_done_pulse", done, 1'b0);
    chk("t5_idle_busy", busy, 1'b0);

    // Test 4: stride 0 means full 16-entry reloads
    start = 1'b1; stride = 4'd0;
    tick();
    start = 1'b0;
    feed(8'h40, 1'b0, 16, nwr, nready, nsv);
    chk("t4_writes", nwr, 16);
    add_scan(4'd4, 8'h40, 16, 8'h00, -1, 0, 1'b0);
    run_tbl(3, nacc);
    chk("t4_refill_ready", in_ready, 1'b1);
    feed(8'h50, 1'b0, 16, nwr, nready, nsv);
    chk("t4_refill_writes", nwr, 16);
    chk("t4_refill_ready_beats", nready, 16);
    add_scan(4'd4, 8'h50, 16, 8'h00, -1, 0, 1'b1);
    run_tbl(4, nacc);
    chk("t4_done", done, 1'b1);
    tick();

    // Test 6: reset after 9 writes
    start = 1'b1; stride = 4'd3;
    tick();
    start = 1'b0;
    feed(8'h60, 1'b0, 9, nwr, nready, nsv);
    chk("t6_pre_writes", nwr, 9);
    rst_n = 1'b0;
    #1;
    chk_idle_outputs("t6_reset");
    #2;
    rst_n = 1'b1;
    tick();
    start = 1'b1; stride = 4'd3;
    tick();
    start = 1'b0;
    feed(8'h70, 1'b0, 16, nwr, nready, nsv);
    chk("t6_writes", nwr, 16);
    chk("t6_no_early_scan", nsv, 0);
    chk("t6_scan_starts", sel_valid, 1'b1);
    chk("t6_sel_head", sel, 4'd0);
    chk("t6_data0", window[0], 8'h70);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
